// File: rtl/xor_checksum.sv
// xor_checksum: accumulates the bitwise XOR and word count of a frame of
// WIDTH-bit words, then holds the result until the consumer takes it.
// A frame is closed by in_last or by reaching MAX_LEN words, in which
// case out_len_err flags the forced close.
// Optional feature macro: XOR_CHECKSUM_COMPARE_EN. When defined, the
// closing word is the expected checksum: it is excluded from out_sum
// (still counted) and out_chk_ok reports whether the two match.
module xor_checksum #(
  parameter int  WIDTH   = 8,
  parameter int  MAX_LEN = 16,
  localparam int CW      = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [CW-1:0]    out_count,
  output logic             out_len_err
`ifdef XOR_CHECKSUM_COMPARE_EN
  ,
  output logic             out_chk_ok
`endif
);

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    count;

  // Combinational helpers derived from current state and inputs.
  logic             in_fire;
  logic             out_fire;
  logic [WIDTH-1:0] acc_nxt;
  logic [CW-1:0]    count_inc;
  logic             hit_max;
  logic             close_beat;

  assign in_fire    = in_valid & (state == ACC);
  assign out_fire   = out_ready & (state == HOLD);
  assign acc_nxt    = acc ^ in_data;
  assign count_inc  = count + CW'(1);
  assign hit_max    = (count_inc == CW'(MAX_LEN));
  assign close_beat = in_fire & (in_last | hit_max);

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACC;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs.
  // NOTE: every signal written here gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACC: begin
        in_ready = 1'b1;
        if (in_valid && (in_last || hit_max)) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = ACC;
        end
      end
      default: state_nxt = ACC;
    endcase
  end

  // Accumulator, word counter and the captured frame result.
  // NOTE: every register here is a plain flop with a reset value; there is
  // no storage array, so nothing is left uninitialised after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      count       <= '0;
      out_sum     <= '0;
      out_count   <= '0;
      out_len_err <= 1'b0;
`ifdef XOR_CHECKSUM_COMPARE_EN
      out_chk_ok  <= 1'b0;
`endif
    end else begin
      if (in_fire) begin
        acc   <= acc_nxt;
        count <= count_inc;
      end else if (out_fire) begin
        // Result consumed: start the next frame from a clean slate.
        acc   <= '0;
        count <= '0;
      end

      if (close_beat) begin
        out_count   <= count_inc;
        // A frame that ends on in_last is a normal close, even when it is
        // also the MAX_LEN-th word.
        out_len_err <= ~in_last;
`ifdef XOR_CHECKSUM_COMPARE_EN
        // Closing word is the expected checksum, not payload.
        out_sum     <= acc;
        out_chk_ok  <= in_last & (acc == in_data);
`else
        out_sum     <= acc_nxt;
`endif
      end
    end
  end

endmodule

// File: tb/tb_xor_checksum.sv
// tb_xor_checksum: self-checking bench for xor_checksum. Two instances
// (WIDTH=8/MAX_LEN=4 and WIDTH=1/MAX_LEN=2) are compared every cycle
// against a frame-level model that keeps each frame's words in a queue and
// computes the expected result when the frame closes. Directed frames with
// literal expectations pin the model. Honours XOR_CHECKSUM_COMPARE_EN.
module tb_xor_checksum;

  localparam int W0  = 8;
  localparam int ML0 = 4;
  localparam int W1  = 1;
  localparam int ML1 = 2;

  logic clk;
  logic rst_n;

  // Instance 0 signals
  logic          iv0, ir0, il0, ov0, or0, oe0;
  logic [W0-1:0] id0, os0;
  logic [2:0]    oc0;
  // Instance 1 signals
  logic          iv1, ir1, il1, ov1, or1, oe1;
  logic [W1-1:0] id1, os1;
  logic [1:0]    oc1;
`ifdef XOR_CHECKSUM_COMPARE_EN
  logic          ok0, ok1;
`endif

  int passed = 0;
  int total  = 0;
  bit run_chk = 0;
  bit done1   = 0;

  xor_checksum #(.WIDTH(W0), .MAX_LEN(ML0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv0), .in_ready(ir0), .in_data(id0), .in_last(il0),
    .out_valid(ov0), .out_ready(or0), .out_sum(os0), .out_count(oc0),
    .out_len_err(oe0)
`ifdef XOR_CHECKSUM_COMPARE_EN
    , .out_chk_ok(ok0)
`endif
  );

  xor_checksum #(.WIDTH(W1), .MAX_LEN(ML1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv1), .in_ready(ir1), .in_data(id1), .in_last(il1),
    .out_valid(ov1), .out_ready(or1), .out_sum(os1), .out_count(oc1),
    .out_len_err(oe1)
`ifdef XOR_CHECKSUM_COMPARE_EN
    , .out_chk_ok(ok1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      passed++;
    end
  endtask

  // ---------------- frame-level reference model ----------------
  logic [63:0] q0[$];
  logic [63:0] q1[$];
  bit          pend0 = 0, pend1 = 0;
  logic [63:0] es0, es1;
  int          ec0, ec1;
  bit          ee0, ee1, eok0, eok1;

  // XOR of the first n words of a frame.
  function automatic logic [63:0] qxor(input logic [63:0] q[$], input int n);
    logic [63:0] s = '0;
    for (int i = 0; i < n; i++) s ^= q[i];
    return s;
  endfunction

  // Result of a closed frame: sum, count, length error, match flag.
  task automatic frame_result(input logic [63:0] q[$], input bit last,
                              output logic [63:0] s, output int n,
                              output bit err, output bit ok);
    n = q.size();
`ifdef XOR_CHECKSUM_COMPARE_EN
    s  = qxor(q, n - 1);
    ok = last && (s == q[n-1]);
`else
    s  = qxor(q, n);
    ok = 1'b0;
`endif
    err = !last;
  endtask

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      q0.delete(); q1.delete(); pend0 = 0; pend1 = 0;
    end else begin
      if (pend0) begin
        if (or0) pend0 = 0;
      end else if (iv0) begin
        q0.push_back(64'(id0));
        if (il0 || q0.size() == ML0) begin
          frame_result(q0, il0, es0, ec0, ee0, eok0);
          pend0 = 1; q0.delete();
        end
      end
      if (pend1) begin
        if (or1) pend1 = 0;
      end else if (iv1) begin
        q1.push_back(64'(id1));
        if (il1 || q1.size() == ML1) begin
          frame_result(q1, il1, es1, ec1, ee1, eok1);
          pend1 = 1; q1.delete();
        end
      end
    end
  end

  // Compare process: every falling edge, both instances against the model.
  initial forever begin
    @(negedge clk);
    if (rst_n && run_chk) begin
      check("m0_in_ready", 64'(ir0), 64'(!pend0));
      check("m0_out_valid", 64'(ov0), 64'(pend0));
      if (pend0) begin
        check("m0_out_sum", 64'(os0), es0);
        check("m0_out_count", 64'(oc0), 64'(ec0));
        check("m0_out_len_err", 64'(oe0), 64'(ee0));
`ifdef XOR_CHECKSUM_COMPARE_EN
        check("m0_out_chk_ok", 64'(ok0), 64'(eok0));
`endif
      end
      check("m1_in_ready", 64'(ir1), 64'(!pend1));
      check("m1_out_valid", 64'(ov1), 64'(pend1));
      if (pend1) begin
        check("m1_out_sum", 64'(os1), es1);
        check("m1_out_count", 64'(oc1), 64'(ec1));
        check("m1_out_len_err", 64'(oe1), 64'(ee1));
`ifdef XOR_CHECKSUM_COMPARE_EN
        check("m1_out_chk_ok", 64'(ok1), 64'(eok1));
`endif
      end
    end
  end

  // Drive instance 0 inputs at a falling edge; accepted at the next rising edge.
  task automatic step0(input logic v, input logic [W0-1:0] d, input logic l);
    @(negedge clk);
    iv0 = v; id0 = d; il0 = l;
  endtask

  task automatic result0(input string name, input logic [7:0] s, input int n,
                         input bit err, input bit ok);
    check({name, "_valid"}, 64'(ov0), 64'd1);
    check({name, "_sum"}, 64'(os0), 64'(s));
    check({name, "_count"}, 64'(oc0), 64'(n));
    check({name, "_len_err"}, 64'(oe0), 64'(err));
`ifdef XOR_CHECKSUM_COMPARE_EN
    check({name, "_chk_ok"}, 64'(ok0), 64'(ok));
`else
    if (ok) check({name, "_chk_ok_unexpected"}, 64'd0, 64'd1);
`endif
  endtask

  // Instance 1: valid toggles every other cycle; stalls carry junk data.
  initial begin
    iv1 = 0; id1 = '0; il1 = 0; or1 = 1;
    @(posedge rst_n);
    @(negedge clk); iv1 = 1; id1 = 1'b1; il1 = 0;
    @(negedge clk); iv1 = 0; id1 = 1'b0; il1 = 1;
    @(negedge clk); iv1 = 1; id1 = 1'b1; il1 = 1;
    @(negedge clk); iv1 = 0; id1 = 1'b0; il1 = 0;
    check("parity_valid", 64'(ov1), 64'd1);
`ifdef XOR_CHECKSUM_COMPARE_EN
    check("parity_sum", 64'(os1), 64'd1);
    check("parity_chk_ok", 64'(ok1), 64'd1);
`else
    check("parity_sum", 64'(os1), 64'd0);
`endif
    check("parity_count", 64'(oc1), 64'd2);
    check("parity_len_err", 64'(oe1), 64'd0);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      iv1 = ~iv1;
      id1 = W1'($urandom);
      il1 = ($urandom_range(0, 2) == 0);
      or1 = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk); iv1 = 0; or1 = 1;
    done1 = 1;
  end

  logic [7:0] wa, wb, wc;

  initial begin
    rst_n = 0; iv0 = 0; id0 = '0; il0 = 0; or0 = 1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(ir0), 64'd1);
    check("rst_out_valid", 64'(ov0), 64'd0);
    check("rst_out_sum", 64'(os0), 64'd0);
    check("rst_out_count", 64'(oc0), 64'd0);
    check("rst_out_len_err", 64'(oe0), 64'd0);
`ifdef XOR_CHECKSUM_COMPARE_EN
    check("rst_out_chk_ok", 64'(ok0), 64'd0);
`endif
    rst_n = 1;
    run_chk = 1;

    // Three-word frame, one-cycle latency, one-cycle input bubble.
    step0(1, 8'h12, 0); step0(1, 8'h34, 0); step0(1, 8'h56, 1);
    step0(0, 8'h00, 0);
`ifdef XOR_CHECKSUM_COMPARE_EN
    result0("f3", 8'h26, 3, 0, 0);
`else
    result0("f3", 8'h70, 3, 0, 0);
`endif
    check("f3_bubble_ready", 64'(ir0), 64'd0);
    step0(0, 8'h00, 0);
    check("f3_ready_back", 64'(ir0), 64'd1);
    check("f3_valid_drop", 64'(ov0), 64'd0);

    // MAX_LEN reached without in_last; fifth word opens a new frame.
    step0(1, 8'h01, 0); step0(1, 8'h02, 0); step0(1, 8'h04, 0); step0(1, 8'h08, 0);
    step0(1, 8'h55, 1);
`ifdef XOR_CHECKSUM_COMPARE_EN
    result0("maxlen", 8'h07, 4, 1, 0);
`else
    result0("maxlen", 8'h0F, 4, 1, 0);
`endif
    step0(1, 8'h55, 1);
    check("maxlen_ready_back", 64'(ir0), 64'd1);
    step0(0, 8'h00, 0);
`ifdef XOR_CHECKSUM_COMPARE_EN
    result0("fifth", 8'h00, 1, 0, 0);
`else
    result0("fifth", 8'h55, 1, 0, 0);
`endif
    step0(0, 8'h00, 0);

    // in_last on the MAX_LEN-th word closes normally.
    step0(1, 8'h03, 0); step0(1, 8'h05, 0); step0(1, 8'h09, 0); step0(1, 8'h11, 1);
    step0(0, 8'h00, 0);
`ifdef XOR_CHECKSUM_COMPARE_EN
    result0("last_at_max", 8'h0F, 4, 0, 0);
`else
    result0("last_at_max", 8'h1E, 4, 0, 0);
`endif
    step0(0, 8'h00, 0);

    // Consumer stalls 5 cycles while random words are offered.
    or0 = 0;
    wa = 8'($urandom); wb = 8'($urandom); wc = 8'($urandom);
    step0(1, wa, 0); step0(1, wb, 0); step0(1, wc, 1);
    for (int i = 0; i < 5; i++) begin
      step0(1, 8'($urandom), 1'($urandom));
      check("stall_ready", 64'(ir0), 64'd0);
      check("stall_valid", 64'(ov0), 64'd1);
`ifdef XOR_CHECKSUM_COMPARE_EN
      check("stall_sum", 64'(os0), 64'(wa ^ wb));
`else
      check("stall_sum", 64'(os0), 64'(wa ^ wb ^ wc));
`endif
      check("stall_count", 64'(oc0), 64'd3);
    end
    @(negedge clk); iv0 = 0; or0 = 1;
    check("stall_release_valid", 64'(ov0), 64'd1);
    check("stall_release_count", 64'(oc0), 64'd3);
    @(negedge clk);
    check("stall_done_ready", 64'(ir0), 64'd1);
    check("stall_done_valid", 64'(ov0), 64'd0);

    // Reset mid-frame discards the partial result.
    step0(1, 8'h11, 0); step0(1, 8'h22, 0);
    @(negedge clk); rst_n = 0; iv0 = 0;
    #1;
    check("midrst_valid", 64'(ov0), 64'd0);
    check("midrst_count", 64'(oc0), 64'd0);
    @(negedge clk); rst_n = 1; iv0 = 1; id0 = 8'hAA; il0 = 1;
    step0(0, 8'h00, 0);
`ifdef XOR_CHECKSUM_COMPARE_EN
    result0("after_rst", 8'h00, 1, 0, 0);
`else
    result0("after_rst", 8'hAA, 1, 0, 0);
`endif
    step0(0, 8'h00, 0);

    // Checksum compare frames.
    step0(1, 8'h0F, 0); step0(1, 8'hF0, 0); step0(1, 8'hFF, 1);
    step0(0, 8'h00, 0);
`ifdef XOR_CHECKSUM_COMPARE_EN
    result0("chk_good", 8'hFF, 3, 0, 1);
`else
    result0("chk_good", 8'h00, 3, 0, 0);
`endif
    step0(0, 8'h00, 0);
    step0(1, 8'h0F, 0); step0(1, 8'hF0, 0); step0(1, 8'hFE, 1);
    step0(0, 8'h00, 0);
`ifdef XOR_CHECKSUM_COMPARE_EN
    result0("chk_bad", 8'hFF, 3, 0, 0);
`else
    result0("chk_bad", 8'h01, 3, 0, 0);
`endif
    step0(0, 8'h00, 0);

    // Randomized traffic, checked by the model every cycle.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      iv0 = ($urandom_range(0, 3) != 0);
      id0 = 8'($urandom);
      il0 = ($urandom_range(0, 2) == 0);
      or0 = ($urandom_range(0, 1) == 1);
    end
    @(negedge clk); iv0 = 0; or0 = 1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 1000 && !done1; i++) @(negedge clk);
    if (!done1) check("bench_timeout", 64'd0, 64'd1);
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
